// File: rtl/power_domain_seq.sv
// Power-down / power-up sequencer for a single switchable domain.
// Every output is registered and decoded from the state being entered.
module power_domain_seq #(
    parameter int CNT_W       = 8,
    parameter int CLK_DLY     = 4,
    parameter int ISO_DLY     = 1,
    parameter int SAVE_CYC    = 2,
    parameter int RESTORE_CYC = 2,
    parameter int RST_DLY     = 4,
    parameter int PWR_TO      = 200
) (
    input  logic       ck,
    input  logic       rn,
    input  logic       pd_req,
    output logic       pd_ack,
    input  logic       pwr_ok,
    output logic       clk_en,
    output logic       iso_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       pwr_en,
    output logic       dom_rst_n,
    output logic       busy,
    output logic       to_err,
    input  logic       err_clr,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        ST_ON        = 4'd0,
        ST_CLK_STOP  = 4'd1,
        ST_ISOLATE   = 4'd2,
        ST_SAVE      = 4'd3,
        ST_PWR_DOWN  = 4'd4,
        ST_OFF       = 4'd5,
        ST_PWR_UP    = 4'd6,
        ST_RESTORE   = 4'd7,
        ST_RST_REL   = 4'd8,
        ST_ISO_REL   = 4'd9,
        ST_CLK_START = 4'd10
    } st_t;

    st_t              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, len;
    logic             ok_s1, ok_s2;
    logic             last, timeout;
    logic             o_clk_en, o_iso_en, o_save, o_restore;
    logic             o_pwr_en, o_rst_n, o_ack, o_busy;

    assign last  = (cnt_q == CNT_W'(1));
    assign state = st_q;

    always_ff @(posedge ck) begin
        if (!rn) begin
            st_q        <= ST_ON;
            cnt_q       <= '0;
            ok_s1       <= 1'b0;
            ok_s2       <= 1'b0;
            clk_en      <= 1'b1;
            iso_en      <= 1'b0;
            ret_save    <= 1'b0;
            ret_restore <= 1'b0;
            pwr_en      <= 1'b1;
            dom_rst_n   <= 1'b1;
            pd_ack      <= 1'b0;
            busy        <= 1'b0;
            to_err      <= 1'b0;
        end else begin
            st_q  <= st_d;
            ok_s1 <= pwr_ok;
            ok_s2 <= ok_s1;
            // Reload on every state change, otherwise count down to zero.
            if (st_d != st_q)
                cnt_q <= len;
            else if (cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            clk_en      <= o_clk_en;
            iso_en      <= o_iso_en;
            ret_save    <= o_save;
            ret_restore <= o_restore;
            pwr_en      <= o_pwr_en;
            dom_rst_n   <= o_rst_n;
            pd_ack      <= o_ack;
            busy        <= o_busy;
            to_err      <= timeout | (to_err & ~err_clr);
        end
    end

    always_comb begin
        st_d    = st_q;
        timeout = 1'b0;
        case (st_q)
            ST_ON:        if (pd_req) st_d = ST_CLK_STOP;
            ST_CLK_STOP:  if (last) st_d = ST_ISOLATE;
            ST_ISOLATE:   if (last) st_d = ST_SAVE;
            ST_SAVE:      if (last) st_d = ST_PWR_DOWN;
            ST_PWR_DOWN: begin
                if (!ok_s2) st_d = ST_OFF;
                else if (last) begin
                    st_d    = ST_OFF;
                    timeout = 1'b1;
                end
            end
            ST_OFF:       if (!pd_req) st_d = ST_PWR_UP;
            ST_PWR_UP: begin
                if (ok_s2) st_d = ST_RESTORE;
                else if (last) begin
                    st_d    = ST_RESTORE;
                    timeout = 1'b1;
                end
            end
            ST_RESTORE:   if (last) st_d = ST_RST_REL;
            ST_RST_REL:   if (last) st_d = ST_ISO_REL;
            ST_ISO_REL:   if (last) st_d = ST_CLK_START;
            ST_CLK_START: if (last) st_d = ST_ON;
            default:      st_d = ST_ON;
        endcase
    end

    // Length loaded into the counter when entering st_d; ON/OFF are untimed.
    always_comb begin
        len = '0;
        case (st_d)
            ST_CLK_STOP, ST_CLK_START: len = CNT_W'(CLK_DLY);
            ST_ISOLATE, ST_ISO_REL:    len = CNT_W'(ISO_DLY);
            ST_SAVE:                   len = CNT_W'(SAVE_CYC);
            ST_RESTORE:                len = CNT_W'(RESTORE_CYC);
            ST_RST_REL:                len = CNT_W'(RST_DLY);
            ST_PWR_DOWN, ST_PWR_UP:    len = CNT_W'(PWR_TO);
            default:                   len = '0;
        endcase
    end

    always_comb begin
        o_clk_en  = (st_d == ST_ON) || (st_d == ST_CLK_START);
        o_iso_en  = (st_d == ST_ISOLATE) || (st_d == ST_SAVE) || (st_d == ST_PWR_DOWN) ||
                    (st_d == ST_OFF) || (st_d == ST_PWR_UP) || (st_d == ST_RESTORE) ||
                    (st_d == ST_RST_REL);
        o_save    = (st_d == ST_SAVE);
        o_restore = (st_d == ST_RESTORE);
        o_pwr_en  = !((st_d == ST_PWR_DOWN) || (st_d == ST_OFF));
        o_rst_n   = !((st_d == ST_PWR_UP) || (st_d == ST_RESTORE));
        // pd_ack reports the last completed sequence, so it stays high through power-up.
        o_ack     = (st_d == ST_OFF) || (st_d == ST_PWR_UP) || (st_d == ST_RESTORE) ||
                    (st_d == ST_RST_REL) || (st_d == ST_ISO_REL) || (st_d == ST_CLK_START);
        o_busy    = !((st_d == ST_ON) || (st_d == ST_OFF));
    end
endmodule

// File: tb/tb_power_domain_seq.sv
// Bench for power_domain_seq: directed sequence timing plus a randomized run
// checked cycle by cycle against a phase/duration reference model.
module tb_power_domain_seq;
    localparam int S_ON = 0, S_CS = 1, S_ISO = 2, S_SAVE = 3, S_PD = 4, S_OFF = 5;
    localparam int S_PU = 6, S_RES = 7, S_RR = 8, S_IR = 9, S_CST = 10;
    localparam int PWR_TO = 200;

    logic ck, rn, pd_req, pwr_ok, err_clr;
    logic pd_ack, clk_en, iso_en, ret_save, ret_restore, pwr_en, dom_rst_n, busy, to_err;
    logic [3:0] state;

    logic         pwr_man, glitch, rail_auto, mon_en;
    int           rail_dly;
    logic [255:0] dl;
    int           n_cmp, n_bad, cyc;
    logic [7:0]   obs;

    power_domain_seq dut (
        .ck(ck), .rn(rn), .pd_req(pd_req), .pd_ack(pd_ack), .pwr_ok(pwr_ok),
        .clk_en(clk_en), .iso_en(iso_en), .ret_save(ret_save), .ret_restore(ret_restore),
        .pwr_en(pwr_en), .dom_rst_n(dom_rst_n), .busy(busy), .to_err(to_err),
        .err_clr(err_clr), .state(state)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Rail model: pwr_ok follows pwr_en after rail_dly+1 cycles, or a manual level.
    always @(negedge ck) dl <= {dl[254:0], pwr_en};
    assign pwr_ok = (rail_auto ? dl[rail_dly] : pwr_man) ^ glitch;
    assign obs = {clk_en, iso_en, ret_save, ret_restore, pwr_en, dom_rst_n, pd_ack, busy};

    // Output levels demanded in each phase, {clk,iso,save,restore,pwr,rst_n,ack,busy}.
    function automatic logic [7:0] exp_vec(input int s);
        case (s)
            S_ON:    return 8'b1000_1100;
            S_CS:    return 8'b0000_1101;
            S_ISO:   return 8'b0100_1101;
            S_SAVE:  return 8'b0110_1101;
            S_PD:    return 8'b0100_0101;
            S_OFF:   return 8'b0100_0110;
            S_PU:    return 8'b0100_1011;
            S_RES:   return 8'b0101_1011;
            S_RR:    return 8'b0100_1111;
            S_IR:    return 8'b0000_1111;
            default: return 8'b1000_1111;
        endcase
    endfunction

    function automatic int phase_len(input int s);
        case (s)
            S_CS, S_CST: return 4;
            S_ISO, S_IR: return 1;
            S_SAVE, S_RES: return 2;
            S_RR: return 4;
            default: return PWR_TO;
        endcase
    endfunction

    function automatic int phase_next(input int s);
        case (s)
            S_CS: return S_ISO;
            S_ISO: return S_SAVE;
            S_SAVE: return S_PD;
            S_RES: return S_RR;
            S_RR: return S_IR;
            S_IR: return S_CST;
            default: return S_ON;
        endcase
    endfunction

    // Reference model: current phase and cycles spent in it; rail status is
    // the pwr_ok seen two edges earlier.
    int   m_st, m_t;
    logic m_err, m_h1, m_h2;
    always @(posedge ck) begin
        logic seen, tout;
        tout = 1'b0;
        if (!rn) begin
            m_st = S_ON; m_t = 0; m_err = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
        end else begin
            seen = m_h2;
            m_h2 = m_h1;
            m_h1 = pwr_ok;
            case (m_st)
                S_ON:  if (pd_req) begin m_st = S_CS; m_t = 1; end
                S_OFF: if (!pd_req) begin m_st = S_PU; m_t = 1; end
                S_PD, S_PU: begin
                    if ((m_st == S_PD) ? !seen : seen) begin
                        m_st = (m_st == S_PD) ? S_OFF : S_RES; m_t = 1;
                    end else if (m_t == PWR_TO) begin
                        tout = 1'b1;
                        m_st = (m_st == S_PD) ? S_OFF : S_RES; m_t = 1;
                    end else m_t++;
                end
                default: begin
                    if (m_t == phase_len(m_st)) begin m_st = phase_next(m_st); m_t = 1; end
                    else m_t++;
                end
            endcase
            if (tout) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        #1;
        if (mon_en) begin
            n_cmp += 6;
            if (state !== 4'(m_st)) begin
                n_bad++; $display("FAIL model_state: got %0d want %0d at cyc %0d", state, m_st, cyc);
            end
            if (obs !== exp_vec(m_st)) begin
                n_bad++; $display("FAIL model_outputs: got %b want %b at cyc %0d", obs, exp_vec(m_st), cyc);
            end
            if (to_err !== m_err) begin
                n_bad++; $display("FAIL model_to_err: got %b want %b at cyc %0d", to_err, m_err, cyc);
            end
            if (clk_en === 1'b1 && !(iso_en === 1'b0 && pwr_en === 1'b1)) begin
                n_bad++; $display("FAIL inv_clk: got iso=%b pwr=%b want 0/1", iso_en, pwr_en);
            end
            if (ret_save === 1'b1 && ret_restore === 1'b1) begin
                n_bad++; $display("FAIL inv_ret: got save=1 restore=1 want not both");
            end
            if (pwr_en === 1'b0 && !(iso_en === 1'b1 && clk_en === 1'b0)) begin
                n_bad++; $display("FAIL inv_pwr: got iso=%b clk=%b want 1/0", iso_en, clk_en);
            end
        end
    end

    task automatic tick();
        @(negedge ck);
        cyc++;
    endtask

    task automatic test_reset();
        rn = 1'b0; pd_req = 1'b0;
        tick(); tick();
        n_cmp += 3;
        if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        if (obs !== 8'b1000_1100) begin n_bad++; $display("FAIL reset_outputs: got %b want 10001100", obs); end
        if (to_err !== 1'b0) begin n_bad++; $display("FAIL reset_to_err: got %b want 0", to_err); end
        rn = 1'b1;
        repeat (3) tick();
        n_cmp += 2;
        if (state !== 4'd0) begin n_bad++; $display("FAIL idle_state: got %0d want 0", state); end
        if (obs !== 8'b1000_1100) begin n_bad++; $display("FAIL idle_outputs: got %b want 10001100", obs); end
    endtask

    task automatic test_power_down();
        int t0 = -1, t1 = -1, t2 = -1, t3 = -1, t4 = -1, tf = -1, ta = -1;
        pwr_man = 1'b1;
        pd_req = 1'b1;
        for (int i = 0; i < 100 && ta < 0; i++) begin
            tick();
            if (t0 < 0 && state == 4'd1 && clk_en == 1'b0) t0 = cyc;
            if (t1 < 0 && iso_en) t1 = cyc;
            if (t2 < 0 && ret_save) t2 = cyc;
            if (t2 >= 0 && t3 < 0 && !ret_save) t3 = cyc;
            if (t4 < 0 && !pwr_en) t4 = cyc;
            if (t4 >= 0 && tf < 0 && cyc == t4 + 3) begin pwr_man = 1'b0; tf = cyc; end
            if (pd_ack) ta = cyc;
        end
        n_cmp += 7;
        if (t1 - t0 != 4) begin n_bad++; $display("FAIL pd_clk_stop_len: got %0d want 4", t1 - t0); end
        if (t2 - t1 != 1) begin n_bad++; $display("FAIL pd_iso_len: got %0d want 1", t2 - t1); end
        if (t3 - t2 != 2) begin n_bad++; $display("FAIL pd_save_len: got %0d want 2", t3 - t2); end
        if (t4 - t0 != 7) begin n_bad++; $display("FAIL pd_pwr_en_fall: got %0d want 7", t4 - t0); end
        // pwr_ok moves at a negedge: two synchronizer edges, then the FSM edge.
        if (ta < 0 || ta - tf != 3) begin n_bad++; $display("FAIL pd_ack_latency: got %0d want 3", ta - tf); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL pd_busy: got %b want 0", busy); end
        if (state !== 4'd5) begin n_bad++; $display("FAIL pd_off_state: got %0d want 5", state); end
    endtask

    task automatic test_power_up();
        int tu = -1, tr = -1, tres = -1, tresf = -1, td = -1, ti = -1, tc = -1, ton = -1, viol = 0;
        pd_req = 1'b0;
        for (int i = 0; i < 100 && ton < 0; i++) begin
            tick();
            if (tu < 0 && state == 4'd6) tu = cyc;
            if (state == 4'd6 && dom_rst_n !== 1'b0) viol++;
            if (ret_restore && dom_rst_n !== 1'b0) viol++;
            if (tu >= 0 && tr < 0 && pwr_en && cyc == tu + 5) begin pwr_man = 1'b1; tr = cyc; end
            if (tres < 0 && ret_restore) tres = cyc;
            if (tres >= 0 && tresf < 0 && !ret_restore) tresf = cyc;
            if (tu >= 0 && td < 0 && dom_rst_n) td = cyc;
            if (tu >= 0 && ti < 0 && !iso_en) ti = cyc;
            if (tu >= 0 && tc < 0 && clk_en) tc = cyc;
            if (tc >= 0 && state == 4'd0) ton = cyc;
        end
        n_cmp += 8;
        if (viol != 0) begin n_bad++; $display("FAIL pu_rst_held: got %0d violations want 0", viol); end
        if (tres - tr != 3) begin n_bad++; $display("FAIL pu_restore_latency: got %0d want 3", tres - tr); end
        if (tresf - tres != 2) begin n_bad++; $display("FAIL pu_restore_len: got %0d want 2", tresf - tres); end
        if (td != tresf) begin n_bad++; $display("FAIL pu_rst_release: got %0d want %0d", td, tresf); end
        if (ti - td != 4) begin n_bad++; $display("FAIL pu_rst_rel_len: got %0d want 4", ti - td); end
        if (tc - ti != 1) begin n_bad++; $display("FAIL pu_iso_rel_len: got %0d want 1", tc - ti); end
        if (ton < 0 || ton - tc != 4) begin n_bad++; $display("FAIL pu_clk_start_len: got %0d want 4", ton - tc); end
        if (pd_ack !== 1'b0) begin n_bad++; $display("FAIL pu_ack: got %b want 0", pd_ack); end
    endtask

    task automatic test_timeout();
        int n4 = 0, n6 = 0;
        pwr_man = 1'b1;
        pd_req = 1'b1;
        for (int i = 0; i < 400 && state != 4'd5; i++) begin
            tick();
            if (state == 4'd4) n4++;
        end
        n_cmp += 2;
        if (n4 != 200) begin n_bad++; $display("FAIL to_down_len: got %0d want 200", n4); end
        if (to_err !== 1'b1) begin n_bad++; $display("FAIL to_down_flag: got %b want 1", to_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (to_err !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", to_err); end
        // Up with the rail stuck off while err_clr is held: set must win at the timeout edge.
        pwr_man = 1'b0;
        tick();
        err_clr = 1'b1;
        pd_req = 1'b0;
        for (int i = 0; i < 400 && state != 4'd7; i++) begin
            tick();
            if (state == 4'd6) n6++;
        end
        n_cmp += 2;
        if (n6 != 200) begin n_bad++; $display("FAIL to_up_len: got %0d want 200", n6); end
        if (to_err !== 1'b1) begin n_bad++; $display("FAIL to_set_wins: got %b want 1", to_err); end
        err_clr = 1'b0;
        for (int i = 0; i < 50 && state != 4'd0; i++) tick();
        pwr_man = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL to_back_on: got %0d want 0", state); end
    endtask

    task automatic test_back_to_back();
        int toff = -1, nxt = -1;
        rail_auto = 1'b1; rail_dly = 3;
        pd_req = 1'b1;
        for (int i = 0; i < 20 && state != 4'd1; i++) tick();
        tick(); tick();
        pd_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (toff >= 0 && nxt < 0) nxt = int'(state);
            if (toff < 0 && state == 4'd5) toff = cyc;
            if (toff >= 0 && state == 4'd0) break;
        end
        n_cmp += 3;
        if (toff < 0) begin n_bad++; $display("FAIL b2b_reached_off: got none want OFF"); end
        if (nxt != 6) begin n_bad++; $display("FAIL b2b_off_to_up: got %0d want 6", nxt); end
        if (state !== 4'd0 || pd_ack !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end_on: got state=%0d ack=%b want 0/0", state, pd_ack);
        end
    endtask

    task automatic test_random();
        int n_off = 0;
        rail_auto = 1'b1; rail_dly = 3;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (state == 4'd5) n_off++;
            glitch = 1'b0;
            if ($urandom_range(0, 39) == 0) pd_req = ~pd_req;
            if ($urandom_range(0, 59) == 0)
                rail_dly = ($urandom_range(0, 7) == 0) ? 250 : int'($urandom_range(0, 10));
            err_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) glitch = 1'b1;
        end
        glitch = 1'b0; err_clr = 1'b0;
        n_cmp++;
        if (n_off == 0) begin n_bad++; $display("FAIL rand_visits_off: got 0 want >0"); end
    endtask

    task automatic test_reset_mid();
        rail_dly = 2; pd_req = 1'b0;
        for (int i = 0; i < 1000 && state != 4'd0; i++) tick();
        pd_req = 1'b1;
        for (int i = 0; i < 50 && state != 4'd3; i++) tick();
        n_cmp++;
        if (state !== 4'd3) begin n_bad++; $display("FAIL rm_reach_save: got %0d want 3", state); end
        rn = 1'b0;
        tick();
        n_cmp += 3;
        if (state !== 4'd0) begin n_bad++; $display("FAIL rm_state: got %0d want 0", state); end
        if (obs !== 8'b1000_1100) begin n_bad++; $display("FAIL rm_outputs: got %b want 10001100", obs); end
        if (to_err !== 1'b0) begin n_bad++; $display("FAIL rm_to_err: got %b want 0", to_err); end
        rn = 1'b1; pd_req = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL rm_stays_on: got %0d want 0", state); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rn = 1'b0; pd_req = 1'b0; err_clr = 1'b0; pwr_man = 1'b1;
        glitch = 1'b0; rail_auto = 1'b0; rail_dly = 0; mon_en = 1'b1;
        test_reset();
        test_power_down();
        test_power_up();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
